// File: rtl/dh_seq_ctrl_pkg.sv
// Shared types and constants for the Dh_cal sequencer: Hq geometry, state
// encoding and the column-major Hq RAM address helper.
package dh_pkg;

    localparam int N        = 16;
    localparam int HQ_ROWS  = 4;
    localparam int HQ_COLS  = 32;
    localparam int DH_COUNT = HQ_COLS / 2;
    localparam int ADDR_W   = 7;
    localparam int TIMEOUT  = 64;
    localparam int Q_W      = 4;
    localparam int QCNT_W   = 5;
    localparam int TMO_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FEED = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_FIN  = 3'd4
    } dh_seq_state_t;

    // Column-major layout: each column occupies HQ_ROWS consecutive words.
    function automatic logic [ADDR_W-1:0] hq_addr_f(input logic [Q_W:0] col,
                                                    input logic [1:0]   row);
        return ADDR_W'(col) * ADDR_W'(HQ_ROWS) + ADDR_W'(row);
    endfunction

endpackage

// File: rtl/dh_feed_addr_gen.sv
// Feed side of the Dh sequencer: element counter, Hq address generation and
// the two-stage read-enable to dh_en pipeline carrying the registered samples.
module dh_feed_addr_gen
    import dh_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              feed,
    input  logic [Q_W-1:0]    q,
    output logic              last_rd,
    output logic              pipe_busy,
    output logic              hq_rd_en,
    output logic [ADDR_W-1:0] hq_addr,
    input  logic [N-1:0]      hq_rd_real,
    input  logic [N-1:0]      hq_rd_im,
    output logic              dh_en,
    output logic [N-1:0]      dh_in_real,
    output logic [N-1:0]      dh_in_im
);

    logic [2:0]   k_q, k_d;
    logic         rd_v_q, rd_v_d;
    logic         dh_en_q, dh_en_d;
    logic [N-1:0] re_q, re_d;
    logic [N-1:0] im_q, im_d;
    logic [Q_W:0] col;

    // k[2] selects column 2q or 2q+1, k[1:0] is the row within that column.
    always_comb begin
        k_d     = '0;
        rd_v_d  = feed;
        dh_en_d = rd_v_q;
        re_d    = re_q;
        im_d    = im_q;
        col     = {q, k_q[2]};
        if (feed) begin
            k_d = k_q + 3'd1;
        end
        if (rd_v_q) begin
            re_d = hq_rd_real;
            im_d = hq_rd_im;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q     <= '0;
            rd_v_q  <= 1'b0;
            dh_en_q <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            k_q     <= k_d;
            rd_v_q  <= rd_v_d;
            dh_en_q <= dh_en_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    assign hq_rd_en   = feed;
    assign hq_addr    = feed ? hq_addr_f(col, k_q[1:0]) : '0;
    assign last_rd    = feed && (k_q == 3'd7);
    assign pipe_busy  = rd_v_q | dh_en_q;
    assign dh_en      = dh_en_q;
    assign dh_in_real = re_q;
    assign dh_in_im   = im_q;

endmodule

// File: rtl/dh_seq_ctrl.sv
// Sequencer for Dh_cal: walks a clamped range of q, feeds the eight Hq
// elements of columns 2q/2q+1 and returns each Dh_q result tagged with q.
module dh_seq_ctrl
    import dh_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [Q_W-1:0]    q_first,
    input  logic [QCNT_W-1:0] q_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              hq_rd_en,
    output logic [ADDR_W-1:0] hq_addr,
    input  logic [N-1:0]      hq_rd_real,
    input  logic [N-1:0]      hq_rd_im,
    output logic              dh_en,
    output logic [N-1:0]      dh_in_real,
    output logic [N-1:0]      dh_in_im,
    input  logic [N-1:0]      dh_out,
    input  logic              dh_result_valid,
    output logic              res_valid,
    output logic [Q_W-1:0]    res_q,
    output logic [N-1:0]      res_data,
    output dh_seq_state_t     dbg_state
);

    dh_seq_state_t     state_q, state_d;
    logic [Q_W-1:0]    q_q, q_d;
    logic [Q_W-1:0]    q_last_q, q_last_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
    logic              run_q, run_d;
    logic              res_valid_q, res_valid_d;
    logic [Q_W-1:0]    res_q_q, res_q_d;
    logic [N-1:0]      res_data_q, res_data_d;

    logic [QCNT_W-1:0] room;
    logic [QCNT_W-1:0] eff;
    logic              feed;
    logic              last_rd;
    logic              pipe_busy;

    // The range never runs past q=15, so addresses stay within 0..127.
    assign room = QCNT_W'(DH_COUNT) - {1'b0, q_first};
    assign eff  = (q_count > room) ? room : q_count;
    assign feed = (state_q == ST_FEED);

    dh_feed_addr_gen u_feed (
        .clk        (clk),
        .rst        (rst),
        .feed       (feed),
        .q          (q_q),
        .last_rd    (last_rd),
        .pipe_busy  (pipe_busy),
        .hq_rd_en   (hq_rd_en),
        .hq_addr    (hq_addr),
        .hq_rd_real (hq_rd_real),
        .hq_rd_im   (hq_rd_im),
        .dh_en      (dh_en),
        .dh_in_real (dh_in_real),
        .dh_in_im   (dh_in_im)
    );

    // dh_result_valid is a single-cycle strobe with no back-pressure; it is
    // honoured only in WAIT. res_valid is a one-cycle strobe the cycle after.
    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        q_last_d    = q_last_q;
        tmo_d       = '0;
        err_d       = err_q;
        run_d       = run_q;
        res_valid_d = 1'b0;
        res_q_d     = res_q_q;
        res_data_d  = res_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (eff == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        err_d    = 1'b0;
                        q_d      = q_first;
                        q_last_d = q_first + eff[Q_W-1:0] - Q_W'(1);
                        run_d    = 1'b1;
                        state_d  = ST_FEED;
                    end
                end
            end
            ST_FEED: begin
                if (last_rd) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Counts cycles since the last dh_en of the group.
                tmo_d = pipe_busy ? TMO_W'(1) : tmo_q + TMO_W'(1);
                if (dh_result_valid) begin
                    res_valid_d = 1'b1;
                    res_q_d     = q_q;
                    res_data_d  = dh_out;
                    state_d     = (q_q == q_last_q) ? ST_FIN : ST_GAP;
                end else if (!pipe_busy && (tmo_q == TMO_W'(TIMEOUT - 1))) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_GAP: begin
                q_d     = q_q + Q_W'(1);
                state_d = ST_FEED;
            end
            ST_FIN: begin
                run_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            q_q         <= '0;
            q_last_q    <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            run_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_q_q     <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            q_last_q    <= q_last_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            run_q       <= run_d;
            res_valid_q <= res_valid_d;
            res_q_q     <= res_q_d;
            res_data_q  <= res_data_d;
        end
    end

    // run_q distinguishes FIN reached from a real run (busy) from a zero-count run.
    assign busy      = (state_q == ST_FEED) || (state_q == ST_WAIT) ||
                       (state_q == ST_GAP)  || ((state_q == ST_FIN) && run_q);
    assign done      = (state_q == ST_FIN);
    assign err       = err_q;
    assign res_valid = res_valid_q;
    assign res_q     = res_q_q;
    assign res_data  = res_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dh_seq_ctrl.sv
// Bench for dh_seq_ctrl: Hq RAM and Dh_cal responders, a run-level reference
// model feeding expected queues, and a monitor that pops and compares.
module tb_dh_seq_ctrl;
    import dh_pkg::*;

    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    q_first = '0;
    logic [4:0]    q_count = '0;
    logic          busy, done, err;
    logic          hq_rd_en;
    logic [6:0]    hq_addr;
    logic [15:0]   hq_rd_real = '0;
    logic [15:0]   hq_rd_im = '0;
    logic          dh_en;
    logic [15:0]   dh_in_real, dh_in_im;
    logic [15:0]   dh_out = '0;
    logic          dh_result_valid = 1'b0;
    logic          res_valid;
    logic [3:0]    res_q;
    logic [15:0]   res_data;
    dh_seq_state_t dbg_state;

    dh_seq_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .q_first         (q_first),
        .q_count         (q_count),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .hq_rd_en        (hq_rd_en),
        .hq_addr         (hq_addr),
        .hq_rd_real      (hq_rd_real),
        .hq_rd_im        (hq_rd_im),
        .dh_en           (dh_en),
        .dh_in_real      (dh_in_real),
        .dh_in_im        (dh_in_im),
        .dh_out          (dh_out),
        .dh_result_valid (dh_result_valid),
        .res_valid       (res_valid),
        .res_q           (res_q),
        .res_data        (res_data),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [6:0]  exp_addr_q[$];
    logic [31:0] exp_feed_q[$];
    logic [19:0] exp_res_q[$];

    logic [15:0] mem_re[128];
    logic [15:0] mem_im[128];

    int   dh_lat = 3;
    bit   dh_mute = 1'b0;
    bit   dh_fixed_en = 1'b0;
    logic [15:0] dh_fixed_val = 16'h0123;
    int   spur_req = 0;

    int rd_cnt = 0, busy_cnt = 0, done_cnt = 0, last_dh_cyc = 0, run_len = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stand-in for the Dh_cal arithmetic: weighted sum of the 8 fed samples.
    function automatic logic [15:0] dh_term(input logic [15:0] re, input logic [15:0] im,
                                            input int idx);
        logic [31:0] p;
        p = 32'(re) * 32'(idx + 1) + 32'(im) * 32'd3;
        return p[15:0];
    endfunction

    // ---------------- Hq RAM responder: data one cycle after the read ----------------
    bit         ram_pend = 1'b0;
    logic [6:0] ram_addr = '0;
    always @(negedge clk) begin
        if (!rst) begin
            ram_pend = 1'b0;
        end else begin
            if (ram_pend) begin
                hq_rd_real = mem_re[ram_addr];
                hq_rd_im   = mem_im[ram_addr];
            end
            ram_pend = hq_rd_en;
            ram_addr = hq_addr;
        end
    end

    // ---------------- Dh_cal behavioural model ----------------
    int          dh_n = 0, dh_wait = 0, spur_ack = 0;
    logic [15:0] dh_acc = '0, dh_res = '0;
    always @(negedge clk) begin
        dh_result_valid = 1'b0;
        if (!rst) begin
            dh_n = 0;
            dh_wait = 0;
            dh_acc = '0;
        end else begin
            if (spur_ack != spur_req) begin
                spur_ack = spur_req;
                dh_result_valid = 1'b1;
                dh_out = 16'hbeef;
            end
            if (dh_wait > 0) begin
                dh_wait--;
                if (dh_wait == 0 && !dh_mute) begin
                    dh_result_valid = 1'b1;
                    dh_out = dh_fixed_en ? dh_fixed_val : dh_res;
                end
            end
            if (dh_en) begin
                dh_acc = dh_acc + dh_term(dh_in_real, dh_in_im, dh_n);
                dh_n++;
                if (dh_n == 8) begin
                    dh_res = dh_acc;
                    dh_acc = '0;
                    dh_n = 0;
                    dh_wait = dh_lat;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            run_len = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (hq_rd_en) begin
                rd_cnt++;
                check("rd_expected", 64'(exp_addr_q.size() > 0), 64'd1);
                if (exp_addr_q.size() > 0)
                    check("hq_addr", 64'(hq_addr), 64'(exp_addr_q.pop_front()));
            end
            if (dh_en) begin
                run_len++;
                last_dh_cyc = cyc;
                check("feed_expected", 64'(exp_feed_q.size() > 0), 64'd1);
                if (exp_feed_q.size() > 0)
                    check("dh_in", 64'({dh_in_real, dh_in_im}), 64'(exp_feed_q.pop_front()));
            end else if (run_len != 0) begin
                check("dh_en_group_len", 64'(run_len), 64'd8);
                run_len = 0;
            end
            if (res_valid) begin
                check("res_expected", 64'(exp_res_q.size() > 0), 64'd1);
                if (exp_res_q.size() > 0)
                    check("res_q_data", 64'({res_q, res_data}), 64'(exp_res_q.pop_front()));
            end
        end
    end

    // ---------------- reference model + driver ----------------
    task automatic push_q(input int q, input bit with_res);
        logic [15:0] acc;
        logic [6:0]  a;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            a = 7'((2 * q + i / 4) * 4 + i % 4);
            exp_addr_q.push_back(a);
            exp_feed_q.push_back({mem_re[a], mem_im[a]});
            acc = acc + dh_term(mem_re[a], mem_im[a], i);
        end
        if (with_res) exp_res_q.push_back({4'(q), dh_fixed_en ? dh_fixed_val : acc});
    endtask

    task automatic do_run(input int qf, input int qc, input bit to_exp, input bit spur_start);
        int n_q, t, rd0, busy0;
        bit got;
        n_q = 0;
        for (int q = qf; q < qf + qc && q < 16; q++) begin
            n_q++;
            if (!to_exp || n_q == 1) push_q(q, !to_exp);
        end
        dh_lat = $urandom_range(1, 8);
        rd0 = rd_cnt;
        busy0 = busy_cnt;
        @(negedge clk);
        q_first = 4'(qf);
        q_count = 5'(qc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(n_q > 0));
        if (n_q > 0) check("err_cleared_on_start", 64'(err), 64'd0);
        got = 1'b0;
        for (t = 0; t < 2000; t++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            start = spur_start && (t == 4);
            if (start) begin
                q_first = 4'($urandom_range(0, 15));
                q_count = 5'($urandom_range(1, 16));
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", 64'(got), 64'd1);
        check("err_at_done", 64'(err), 64'(to_exp));
        if (to_exp) check("timeout_latency", 64'(cyc - last_dh_cyc), 64'(TMO));
        if (n_q == 0) begin
            check("zero_done_latency", 64'(t <= 1), 64'd1);
            check("zero_no_reads", 64'(rd_cnt - rd0), 64'd0);
            check("zero_no_busy", 64'(busy_cnt - busy0), 64'd0);
        end
        @(negedge clk);
        check("done_one_cycle_busy_low", 64'({done, busy}), 64'd0);
        check("queues_drained",
              64'(exp_addr_q.size() + exp_feed_q.size() + exp_res_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 64'({busy, done, err, hq_rd_en, hq_addr, dh_en, res_valid, res_q}),
              64'd0);
        check({tag, "_data"}, 64'({dh_in_real, dh_in_im, res_data}), 64'd0);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 128; i++) begin
            mem_re[i] = 16'(i);
            mem_im[i] = 16'(i) ^ 16'h5a5a;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single q with ramp data and a fixed Dh result.
        dh_fixed_en = 1'b1;
        do_run(0, 1, 1'b0, 1'b0);
        dh_fixed_en = 1'b0;

        // Full run on random Hq contents.
        for (int i = 0; i < 128; i++) begin
            mem_re[i] = 16'($urandom);
            mem_im[i] = 16'($urandom);
        end
        do_run(0, 16, 1'b0, 1'b0);

        // Clamped range, then zero count with a stray Dh valid while idle.
        do_run(14, 5, 1'b0, 1'b0);
        spur_req++;
        repeat (3) @(negedge clk);
        check("err_after_stray_valid", 64'(err), 64'd0);
        do_run(5, 0, 1'b0, 1'b0);

        // Timeout, then a normal run that must clear err.
        dh_mute = 1'b1;
        do_run($urandom_range(0, 13), 3, 1'b1, 1'b0);
        dh_mute = 1'b0;
        do_run($urandom_range(0, 15), 2, 1'b0, 1'b0);

        // Reset while feeding at k=3.
        push_q(6, 1'b1);
        @(negedge clk);
        q_first = 4'd6;
        q_count = 5'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rd_at_feed_entry", 64'(hq_rd_en), 64'd1);
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset");
        exp_addr_q.delete();
        exp_feed_q.delete();
        exp_res_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("no_done_on_reset", 64'(done_cnt - d0), 64'd0);

        // Normal run with a start pulse injected while busy.
        do_run(3, 4, 1'b0, 1'b1);

        for (int r = 0; r < 6; r++)
            do_run($urandom_range(0, 15), $urandom_range(0, 18), 1'b0, r[0]);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
